// File: rtl/game_console_ctrl.sv
// Console sequencer: game-select menu, launch/reset sequencing, key routing,
// RGB muxing and per-game high scores.
//   in : clk, rst, VS, Coloana, Linie, InDisplay, keyboard, valid,
//        game_rgb, game_over, game_score
//   out: game_rst, kb_out, kb_valid, red, green, blue, active, state,
//        high_score
module game_console_ctrl #(
  parameter int          NUM_GAMES     = 2,
  parameter int          LAUNCH_FRAMES = 2,
  parameter int          OVER_FRAMES   = 180,
  parameter logic [7:0]  KEY_UP        = 8'h75,
  parameter logic [7:0]  KEY_DOWN      = 8'h72,
  parameter logic [7:0]  KEY_ENTER     = 8'h5A,
  parameter logic [7:0]  KEY_ESC       = 8'h76,
  parameter int          BAND_Y0       = 112,
  parameter int          BAND_H        = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      VS,
  input  logic [9:0]                Coloana,
  input  logic [9:0]                Linie,
  input  logic                      InDisplay,
  input  logic [7:0]                keyboard,
  input  logic                      valid,
  input  logic [12*NUM_GAMES-1:0]   game_rgb,
  input  logic [NUM_GAMES-1:0]      game_over,
  input  logic [14*NUM_GAMES-1:0]   game_score,
  output logic [NUM_GAMES-1:0]      game_rst,
  output logic [7:0]                kb_out,
  output logic [NUM_GAMES-1:0]      kb_valid,
  output logic [3:0]                red,
  output logic [3:0]                green,
  output logic [3:0]                blue,
  output logic [1:0]                active,
  output logic [1:0]                state,
  output logic [14*NUM_GAMES-1:0]   high_score
);

  typedef enum logic [1:0] {
    MENU   = 2'd0,
    LAUNCH = 2'd1,
    PLAY   = 2'd2,
    OVER   = 2'd3
  } st_t;

  st_t st, st_n;
  logic [1:0] act_n;
  logic [7:0] cnt, cnt_n, cnt_sat;
  logic vs_d, tick;
  logic fwd, hs_load;
  logic [NUM_GAMES-1:0] oh, oh_n, grst_n;
  logic [11:0] sel_rgb, pix;
  logic sel_over;
  logic [13:0] sel_score, sel_hs;
  logic [10:0] lin;
  logic in_col;

  assign state   = st;
  assign tick    = vs_d & ~VS;
  assign cnt_sat = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  assign lin     = {1'b0, Linie};
  assign in_col  = (Coloana >= 10'd304) && (Coloana < 10'd624);

  // Slot selection by the current and next active index.
  always_comb begin
    sel_rgb   = '0;
    sel_over  = 1'b0;
    sel_score = '0;
    sel_hs    = '0;
    oh        = '0;
    oh_n      = '0;
    for (int g = 0; g < NUM_GAMES; g++) begin
      if (active == 2'(g)) begin
        sel_rgb   = game_rgb[12*g +: 12];
        sel_over  = game_over[g];
        sel_score = game_score[14*g +: 14];
        sel_hs    = high_score[14*g +: 14];
        oh[g]     = 1'b1;
      end
      if (act_n == 2'(g)) oh_n[g] = 1'b1;
    end
  end

  always_comb begin
    st_n    = st;
    act_n   = active;
    cnt_n   = tick ? cnt_sat : cnt;
    fwd     = 1'b0;
    hs_load = 1'b0;
    unique case (st)
      MENU: begin
        if (valid) begin
          if (keyboard == KEY_UP)
            act_n = (active == 2'd0) ?
                    2'(NUM_GAMES-1) : active - 2'd1;
          else if (keyboard == KEY_DOWN)
            act_n = (active == 2'(NUM_GAMES-1)) ?
                    2'd0 : active + 2'd1;
          else if (keyboard == KEY_ENTER)
            st_n = LAUNCH;
        end
      end
      LAUNCH: begin
        if (tick && int'(cnt_sat) >= LAUNCH_FRAMES)
          st_n = PLAY;
      end
      PLAY: begin
        fwd = valid && (keyboard != KEY_ESC);
        // Game over takes priority over a simultaneous ESC.
        if (sel_over) begin
          st_n    = OVER;
          hs_load = sel_score > sel_hs;
        end else if (valid && keyboard == KEY_ESC) begin
          st_n = MENU;
        end
      end
      OVER: begin
        if ((valid && keyboard == KEY_ENTER) ||
            (tick && int'(cnt_sat) >= OVER_FRAMES))
          st_n = MENU;
      end
    endcase
    if (st_n != st) cnt_n = '0;
    // The active game runs in PLAY and stays frozen-visible in OVER.
    if (st_n == PLAY || st_n == OVER) grst_n = ~oh_n;
    else grst_n = '1;
  end

  always_comb begin
    pix = '0;
    if (InDisplay) begin
      unique case (st)
        MENU: begin
          pix = 12'h004;
          if (in_col) begin
            for (int i = 0; i < NUM_GAMES; i++) begin
              if (lin >= 11'(BAND_Y0 + i*BAND_H) &&
                  lin <  11'(BAND_Y0 + (i+1)*BAND_H - 8))
                pix = (active == 2'(i)) ? 12'hFF0 : 12'h888;
            end
          end
        end
        LAUNCH: pix = '0;
        PLAY:   pix = sel_rgb;
        OVER: begin
          pix = sel_rgb;
          if (Linie < 10'd40) pix[11:8] = 4'hF;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d       <= 1'b0;
      st         <= MENU;
      active     <= 2'd0;
      cnt        <= '0;
      game_rst   <= '1;
      kb_out     <= '0;
      kb_valid   <= '0;
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      high_score <= '0;
    end else begin
      vs_d     <= VS;
      st       <= st_n;
      active   <= act_n;
      cnt      <= cnt_n;
      game_rst <= grst_n;
      kb_valid <= fwd ? oh : '0;
      if (fwd) kb_out <= keyboard;
      for (int g = 0; g < NUM_GAMES; g++)
        if (hs_load && oh[g])
          high_score[14*g +: 14] <= sel_score;
      red   <= pix[11:8];
      green <= pix[7:4];
      blue  <= pix[3:0];
    end
  end

endmodule

// File: doc/game_console_ctrl.md
Name: game_console_ctrl

Overview:
- Top-level console sequencer sitting between the VGA timing generator, PS/2 keyboard decoder and the per-game modules (Flappy Bird, etc.).
- Runs a game-select menu and launches the chosen game by holding it in reset, then releasing it.
- Routes keyboard events only to the active game and muxes that game's RGB onto the VGA pins.
- Tracks a per-game high score and returns to the menu after game over.

Parameters:
- NUM_GAMES, 2, number of game slots (1..4).
- LAUNCH_FRAMES, 2, frame ticks the selected game is held in reset on launch. Covers games that sample rst on VS edges.
- OVER_FRAMES, 180, frame ticks the game-over screen is held before auto-return to menu.
- KEY_UP, 8'h75, scan code for cursor up.
- KEY_DOWN, 8'h72, scan code for cursor down.
- KEY_ENTER, 8'h5A, scan code for select/confirm.
- KEY_ESC, 8'h76, scan code for abort.
- BAND_Y0, 112, first menu line of band 0 (VS_min=32 based).
- BAND_H, 64, height in lines of each menu band.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- VS  in  1  vertical sync from VGA timing
- Coloana  in  10  current column
- Linie  in  10  current line
- InDisplay  in  1  pixel is visible
- keyboard  in  8  scan code
- valid  in  1  one-cycle strobe, keyboard is valid
- game_rgb  in  12*NUM_GAMES  per-game {red,green,blue}; slot g at [12g+11:12g]
- game_over  in  NUM_GAMES  per-game game-over flag
- game_score  in  14*NUM_GAMES  per-game score; slot g at [14g+13:14g]
- game_rst  out  NUM_GAMES  per-game reset, active-high
- kb_out  out  8  scan code forwarded to games
- kb_valid  out  NUM_GAMES  per-game valid strobe
- red / green / blue  out  4 each  VGA colour
- active  out  2  index of selected/active game
- state  out  2  0=MENU, 1=LAUNCH, 2=PLAY, 3=OVER
- high_score  out  14*NUM_GAMES  per-game best score

Behaviour:
- Reset values: state=MENU, active=0, game_rst=all 1, kb_valid=0, kb_out=0, RGB=0, high_score=all 0, frame counter=0.
- Frame tick:
  - VS is registered once (vs_d).
  - frame_tick = vs_d & ~VS, one cycle per frame.
- MENU:
  - All game_rst=1.
  - KEY_UP: active-1, wrapping 0 -> NUM_GAMES-1.
  - KEY_DOWN: active+1, wrapping NUM_GAMES-1 -> 0.
  - KEY_ENTER: go to LAUNCH with frame counter cleared.
  - Other codes are ignored. Keys act only on cycles where valid=1.
- LAUNCH:
  - game_rst[active]=1; all others 1.
  - Count frame ticks; on reaching LAUNCH_FRAMES go to PLAY. game_rst[active] falls in the same cycle state becomes PLAY.
- PLAY:
  - game_rst[active]=0, all others 1.
  - On valid with code != KEY_ESC: next cycle kb_out=keyboard and kb_valid[active]=1, exactly one cycle. kb_out is otherwise held at its last value.
  - KEY_ESC is never forwarded. It moves to MENU; high score is not updated.
  - game_over[active]=1: go to OVER with frame counter cleared. If game_score[active] > high_score[active], load it in the same cycle.
  - If game_over and an ESC valid occur in the same cycle, game_over wins.
  - game_over of non-active slots is ignored.
- OVER:
  - game_rst[active] stays 0 so the frozen game screen remains visible. No keys are forwarded.
  - Go to MENU on KEY_ENTER or when the frame counter reaches OVER_FRAMES; all game_rst return to 1 there.
- kb_valid: outside PLAY all kb_valid=0.
- Pixel output: registered, 1-cycle latency from Coloana/Linie/InDisplay/game_rgb.
  - InDisplay=0: black.
  - MENU: band i covers Linie in [BAND_Y0+i*BAND_H, BAND_Y0+(i+1)*BAND_H-8) and Coloana in [304,624).
    - Band i with i==active: F,F,0.
    - Other bands for i<NUM_GAMES: 8,8,8.
    - Elsewhere: 0,0,4.
  - LAUNCH: black.
  - PLAY: game_rgb[active].
  - OVER: game_rgb[active] with red forced to F on Linie<40 (top banner).
- Frame counter: 8 bits, saturating, cleared on every state entry.
- Reset mid-operation: everything returns to reset values on the next edge, high_score included.

Test Plan:
- Reset, then DOWN, DOWN, UP, UP, UP strobes with NUM_GAMES=2 -> active sequence 1,0,1,0,1; state=0; game_rst=2'b11.
- active=0, ENTER -> state=1 for exactly 2 VS falling edges, game_rst[0]=1 throughout, then state=2 with game_rst=2'b10.
- PLAY slot 0, scan code 8'h29 with valid -> next cycle kb_out=8'h29, kb_valid=2'b01 for one cycle. Then ESC -> no kb_valid, state=0, game_rst=2'b11.
- PLAY slot 1, game_score[1]=37, game_over[1]=1 -> state=3, high_score[1]=37. Repeat with score 20 -> high_score[1] stays 37. After 180 frame ticks with no key -> state=0.
- PLAY, game_over[0]=1 and ESC valid in the same cycle -> state=3, high score updated, kb_valid=0.
- MENU, active=1, pixel Linie=200, Coloana=400, InDisplay=1 -> one cycle later RGB=F,F,0. Same pixel with InDisplay=0 -> RGB=0.
